// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - raster timing bundle from vga_sync_gen to the renderers
// frame_count is present only when VGA_FRAME_CNT_EN is defined.
interface vga_sync_gen_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync;
  logic        vsync;
  logic        frame_start;
  logic        line_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_count;

  modport master (
    output pixel_x, pixel_y, video_on, hsync, vsync, frame_start, line_end, frame_count
  );
  modport slave (
    input pixel_x, pixel_y, video_on, hsync, vsync, frame_start, line_end, frame_count
  );
`else
  modport master (
    output pixel_x, pixel_y, video_on, hsync, vsync, frame_start, line_end
  );
  modport slave (
    input pixel_x, pixel_y, video_on, hsync, vsync, frame_start, line_end
  );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - free-running 640x480@60 raster counters, video_on and delayed syncs
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int SYNC_DLY  = 1
) (
  input  logic           clk_d,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DLY < 0 || SYNC_DLY > 4) begin : g_bad_dly
      $error("vga_sync_gen: SYNC_DLY must be in 0..4");
    end
  endgenerate

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_video_on;
  logic       r_frame_start;
  logic       r_line_end;

  logic       w_x_wrap;
  logic [9:0] w_x_next;
  logic [9:0] w_y_next;
  logic       w_hs_raw;
  logic       w_vs_raw;
  logic       w_frame_next;

  always_comb begin
    w_x_wrap = (r_x == H_LAST);
    w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
    end
    w_frame_next = (w_x_next == 10'd0) && (w_y_next == 10'd0);
    // Sync windows are decoded from the next-state counters so stage 0 lines up with pixel_x/pixel_y.
    w_hs_raw = ((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    w_vs_raw = ((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_x           <= H_LAST;
      r_y           <= V_LAST;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b1;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_video_on    <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
      r_frame_start <= w_frame_next;
      r_line_end    <= (w_x_next == H_LAST);
    end
  end

  generate
    if (SYNC_DLY == 0) begin : g_sync_nodly
      logic r_hs;
      logic r_vs;

      always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
          r_hs <= ~SYNC_POL;
          r_vs <= ~SYNC_POL;
        end else begin
          r_hs <= w_hs_raw;
          r_vs <= w_vs_raw;
        end
      end

      assign vga.hsync = r_hs;
      assign vga.vsync = r_vs;
    end else begin : g_sync_dly
      // Stage 0 is counter-aligned; stage SYNC_DLY matches the renderers' colour register delay.
      logic [SYNC_DLY:0] r_hs_pipe;
      logic [SYNC_DLY:0] r_vs_pipe;

      always_ff @(posedge clk_d or posedge reset) begin
        if (reset) begin
          r_hs_pipe <= {(SYNC_DLY + 1){~SYNC_POL}};
          r_vs_pipe <= {(SYNC_DLY + 1){~SYNC_POL}};
        end else begin
          r_hs_pipe <= {r_hs_pipe[SYNC_DLY-1:0], w_hs_raw};
          r_vs_pipe <= {r_vs_pipe[SYNC_DLY-1:0], w_vs_raw};
        end
      end

      assign vga.hsync = r_hs_pipe[SYNC_DLY];
      assign vga.vsync = r_vs_pipe[SYNC_DLY];
    end
  endgenerate

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      r_frame_count <= 16'd0;
    end else if (w_frame_next) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`endif

  assign vga.pixel_x     = r_x;
  assign vga.pixel_y     = r_y;
  assign vga.video_on    = r_video_on;
  assign vga.frame_start = r_frame_start;
  assign vga.line_end    = r_line_end;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen (default and reduced rasters)
// Reference model derives every output from the number of clock edges since reset release.
module tb_vga_sync_gen;

  typedef struct {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    bit pol;
    int dly;
  } cfg_t;

  typedef struct {
    int k;
    int x;
    int y;
    bit von;
    bit hs;
    bit vs;
    bit fs;
    bit le;
  } vec_t;

  logic clk_d;
  logic reset;
  int   k;
  int   n_tests;
  int   n_fail;

  cfg_t cfg_a;
  cfg_t cfg_b;
  cfg_t cfg_c;

  bit   track_en;
  int   a_von_cnt;
  int   a_le_cnt;
  int   b_fs_k[2];
  int   nb_fs;
  int   b_vs_cnt;
  int   b_vs_first;
  int   b_fc_seen;

  vec_t tab[12];

  vga_sync_gen_if ifa();
  vga_sync_gen_if ifb();
  vga_sync_gen_if ifc();

  vga_sync_gen u_dut_a (
    .clk_d (clk_d),
    .reset (reset),
    .vga   (ifa)
  );

  vga_sync_gen #(
    .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .SYNC_DLY(2)
  ) u_dut_b (
    .clk_d (clk_d),
    .reset (reset),
    .vga   (ifb)
  );

  vga_sync_gen #(
    .H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .SYNC_DLY(0)
  ) u_dut_c (
    .clk_d (clk_d),
    .reset (reset),
    .vga   (ifc)
  );

  initial clk_d = 1'b0;
  always #5 clk_d = ~clk_d;

  function automatic int total(input cfg_t c);
    return (c.hv + c.hf + c.hs + c.hb) * (c.vv + c.vf + c.vs + c.vb);
  endfunction

  // Expected {x, y, video_on, hsync, vsync, frame_start, line_end} after k edges.
  function automatic logic [24:0] model(input cfg_t c, input int kk);
    int ht;
    int tot;
    int p;
    int pd;
    int x;
    int y;
    int xd;
    int yd;
    logic hact;
    logic vact;
    logic hs;
    logic vs;
    ht  = c.hv + c.hf + c.hs + c.hb;
    tot = total(c);
    p   = (kk + tot - 1) % tot;
    x   = p % ht;
    y   = p / ht;
    hact = 1'b0;
    vact = 1'b0;
    if (kk >= c.dly) begin
      pd   = (kk - c.dly + tot - 1) % tot;
      xd   = pd % ht;
      yd   = pd / ht;
      hact = (xd >= c.hv + c.hf) && (xd < c.hv + c.hf + c.hs);
      vact = (yd >= c.vv + c.vf) && (yd < c.vv + c.vf + c.vs);
    end
    hs = hact ? c.pol : ~c.pol;
    vs = vact ? c.pol : ~c.pol;
    return {x[9:0], y[9:0], (x < c.hv) && (y < c.vv), hs, vs, (x == 0) && (y == 0), (x == ht - 1)};
  endfunction

  function automatic int fc_model(input cfg_t c, input int kk);
    if (kk == 0) return 0;
    return ((kk - 1) / total(c) + 1) % 65536;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  task automatic check_cycle();
    chk("a_outputs", 32'({ifa.pixel_x, ifa.pixel_y, ifa.video_on, ifa.hsync, ifa.vsync,
                          ifa.frame_start, ifa.line_end}), 32'(model(cfg_a, k)));
    chk("b_outputs", 32'({ifb.pixel_x, ifb.pixel_y, ifb.video_on, ifb.hsync, ifb.vsync,
                          ifb.frame_start, ifb.line_end}), 32'(model(cfg_b, k)));
    chk("c_outputs", 32'({ifc.pixel_x, ifc.pixel_y, ifc.video_on, ifc.hsync, ifc.vsync,
                          ifc.frame_start, ifc.line_end}), 32'(model(cfg_c, k)));
`ifdef VGA_FRAME_CNT_EN
    chk("a_frame_count", 32'(ifa.frame_count), 32'(fc_model(cfg_a, k)));
    chk("b_frame_count", 32'(ifb.frame_count), 32'(fc_model(cfg_b, k)));
`endif
  endtask

  task automatic step();
    @(posedge clk_d);
    if (!reset) k++;
    #2;
    check_cycle();
    if (track_en) begin
      if (k >= 801 && k <= 1600) begin
        a_von_cnt += int'(ifa.video_on);
        a_le_cnt  += int'(ifa.line_end);
      end
      if (ifb.frame_start && nb_fs < 2) begin
        b_fs_k[nb_fs] = k;
        nb_fs++;
      end
      if (k >= 1 && k <= 135 && ifb.vsync) begin
        b_vs_cnt++;
        if (b_vs_first < 0) b_vs_first = k;
      end
`ifdef VGA_FRAME_CNT_EN
      if (ifb.frame_start && b_fc_seen < 3) begin
        b_fc_seen++;
        chk("b_frame_count_pulse", 32'(ifb.frame_count), 32'(b_fc_seen));
      end
`endif
    end
  endtask

  initial begin
    int run;
    int hold;
    n_tests = 0;
    n_fail  = 0;
    k       = 0;
    reset   = 1'b1;
    cfg_a = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1};
    cfg_b = '{8, 2, 3, 2, 4, 1, 2, 2, 1'b1, 2};
    cfg_c = '{5, 1, 2, 1, 3, 1, 1, 1, 1'b0, 0};
    track_en   = 1'b0;
    a_von_cnt  = 0;
    a_le_cnt   = 0;
    nb_fs      = 0;
    b_vs_cnt   = 0;
    b_vs_first = -1;
    b_fc_seen  = 0;

    //          k     x    y   von hs vs fs le
    tab[0]  = '{0,    799, 524, 0, 1, 1, 0, 1};
    tab[1]  = '{1,    0,   0,   1, 1, 1, 1, 0};
    tab[2]  = '{2,    1,   0,   1, 1, 1, 0, 0};
    tab[3]  = '{640,  639, 0,   1, 1, 1, 0, 0};
    tab[4]  = '{641,  640, 0,   0, 1, 1, 0, 0};
    tab[5]  = '{657,  656, 0,   0, 1, 1, 0, 0};
    tab[6]  = '{658,  657, 0,   0, 0, 1, 0, 0};
    tab[7]  = '{753,  752, 0,   0, 0, 1, 0, 0};
    tab[8]  = '{754,  753, 0,   0, 1, 1, 0, 0};
    tab[9]  = '{800,  799, 0,   0, 1, 1, 0, 1};
    tab[10] = '{801,  0,   1,   1, 1, 1, 0, 0};
    tab[11] = '{1601, 0,   2,   1, 1, 1, 0, 0};

    repeat (2) step();
    chk("b_idle_sync_after_reset", 32'({ifb.hsync, ifb.vsync}), 32'(2'b00));
    #1 reset = 1'b0;
    track_en = 1'b1;

    for (int i = 0; i < 12; i++) begin
      while (k < tab[i].k) step();
      chk($sformatf("vec%0d", i),
          32'({ifa.pixel_x, ifa.pixel_y, ifa.video_on, ifa.hsync, ifa.vsync,
               ifa.frame_start, ifa.line_end}),
          32'({10'(tab[i].x), 10'(tab[i].y), tab[i].von, tab[i].hs, tab[i].vs,
               tab[i].fs, tab[i].le}));
    end
    track_en = 1'b0;

    chk("a_line_video_on_count", 32'(a_von_cnt), 32'd640);
    chk("a_line_end_count", 32'(a_le_cnt), 32'd1);
    chk("b_first_frame_start_k", 32'(b_fs_k[0]), 32'd1);
    chk("b_frame_period", 32'(b_fs_k[1] - b_fs_k[0]), 32'd135);
    chk("b_vsync_active_cycles", 32'(b_vs_cnt), 32'd30);
    chk("b_vsync_first_active_k", 32'(b_vs_first), 32'd78);

    // Mid-line reset on the default raster: x=300, y=2.
    while (k < 1901) step();
    chk("a_pre_reset_pos", 32'({ifa.pixel_x, ifa.pixel_y}), 32'({10'd300, 10'd2}));
    #1 reset = 1'b1;
    k = 0;
    #1;
    chk("a_async_reset_state",
        32'({ifa.pixel_x, ifa.pixel_y, ifa.video_on, ifa.hsync, ifa.vsync,
             ifa.frame_start, ifa.line_end}),
        32'({10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}));
    repeat (3) step();
    #1 reset = 1'b0;
    step();
    chk("a_first_edge_after_reset",
        32'({ifa.pixel_x, ifa.pixel_y, ifa.video_on, ifa.frame_start, ifa.line_end}),
        32'({10'd0, 10'd0, 1'b1, 1'b1, 1'b0}));

    for (int it = 0; it < 40; it++) begin
      run = int'($urandom_range(1, 1500));
      repeat (run) step();
      if ($urandom_range(0, 2) == 0) begin
        #1 reset = 1'b1;
        k = 0;
        #1 check_cycle();
        hold = int'($urandom_range(1, 4));
        repeat (hold) step();
        #1 reset = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Upstream timing stage for all screen renderers (start screen, game field, score overlay).
- Runs on the pixel clock and generates the 640x480@60 Hz raster: pixel_x, pixel_y, video_on and hsync/vsync.
- Renderers register their colour outputs one cycle after pixel_x/pixel_y. This block delays hsync/vsync by a matching amount so sync stays aligned with colour at the connector.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_POL, 0, active sync level (0 = active-low)
- SYNC_DLY, 1, pipeline delay of hsync/vsync relative to pixel_x/pixel_y (0..4)

Ports:
- clk_d  input  1  pixel clock (25 MHz)
- reset  input  1  asynchronous, active-high reset
- pixel_x  output  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  output  10  vertical counter, 0..V_TOTAL-1
- video_on  output  1  high when pixel_x<H_VISIBLE and pixel_y<V_VISIBLE
- hsync  output  1  horizontal sync, delayed SYNC_DLY cycles
- vsync  output  1  vertical sync, delayed SYNC_DLY cycles
- frame_start  output  1  one-cycle pulse while (pixel_x,pixel_y)=(0,0)
- line_end  output  1  one-cycle pulse while pixel_x=H_TOTAL-1

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the H parameters = 800.
  - V_TOTAL = sum of the V parameters = 525.
  - Both must be <=1024; otherwise the block issues an elaboration error.
- Counting:
  - pixel_x increments every clk_d and wraps from H_TOTAL-1 to 0.
  - pixel_y increments only on that wrap, and wraps from V_TOTAL-1 to 0 on the same edge pixel_x wraps.
- All outputs are registered. video_on, frame_start and line_end are computed from the next-state counter values so they align exactly with pixel_x/pixel_y. Latency is zero relative to the counters.
- Raw sync windows:
  - hsync active for pixel_x in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1], i.e. [656,751].
  - vsync active for pixel_y in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1], i.e. [490,491].
  - Active level is SYNC_POL; inactive level is ~SYNC_POL.
- Sync delay:
  - Raw hsync/vsync pass through a SYNC_DLY-deep shift register.
  - SYNC_DLY=0 means the syncs are registered alongside the counters with no extra stages.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1.
  - video_on = 0, frame_start = 0, line_end = 1.
  - hsync, vsync and every delay stage = inactive level.
- First clock edge after reset deassertion: pixel_x=0, pixel_y=0, video_on=1, frame_start=1, line_end=0.
- Blanking: pixel_x/pixel_y keep counting through the porches. video_on=0 whenever either counter is outside its visible range.
- Simultaneous wrap at (H_TOTAL-1, V_TOTAL-1):
  - Next cycle is (0,0) with frame_start=1.
  - line_end is high in the wrap cycle itself.
- No enable input: the counters free-run continuously.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count [15:0].
  - Resets to 0 and increments by 1 on every frame_start pulse; wraps 16'hFFFF to 0.
  - Used by game logic as a 60 Hz timebase and by renderers to blink text.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert reset for 3 cycles mid-frame (pixel_x=300, pixel_y=200) -> outputs go immediately to x=799, y=524, video_on=0, hsync=vsync=1 (SYNC_POL=0). First edge after release gives x=0, y=0, video_on=1, frame_start=1.
- Line timing: run one full line -> video_on high for exactly 640 clocks and low for 160; line_end high only at x=799; y increments 0->1 on the next edge.
- Hsync alignment, SYNC_DLY=1: raw window at x=656..751 -> hsync low from the cycle x=657 through x=752 (96 clocks), high elsewhere.
- Frame timing: run 2 frames -> frame_start pulses 420000 clocks apart; vsync low for exactly 1600 clocks (2 lines) beginning one cycle after (x,y)=(0,490).
- Wrap: at (799,524) -> next cycle (0,0), frame_start=1, no intermediate (0,525) state. With SYNC_POL=1, check syncs are active-high and idle low after reset.
- VGA_FRAME_CNT_EN defined: 3 frames after reset -> frame_count reads 1, 2, 3 at successive frame_start pulses. Preload to 16'hFFFF -> next frame reads 0.
